// File: rtl/lpc_pkg.sv
// Shared types and helpers for the LPC record scheduler: record layout,
// scheduler FSM encoding, cycle-type codes and frame header layout.
package lpc_pkg;

  typedef struct packed {
    logic [3:0]  ct_dir;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
  } lpc_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } lpc_state_e;

  localparam logic [3:0] CT_IO_RD  = 4'b0000;
  localparam logic [3:0] CT_IO_WR  = 4'b0010;
  localparam logic [3:0] CT_MEM_RD = 4'b0100;
  localparam logic [3:0] CT_MEM_WR = 4'b0110;

  // Header byte: {ct_dir[7:4], lost[3], size[2:0]}
  localparam int HDR_CT_LSB   = 4;
  localparam int HDR_LOST_BIT = 3;
  localparam int HDR_SIZE_LSB = 0;

  function automatic logic [2:0] data_bytes(input logic [2:0] size);
    return (size > 3'd4) ? 3'd4 : size;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
    logic [31:0] s;
    s = w >> {idx, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [7:0] hdr_byte(input lpc_rec_t rec, input logic lost);
    return {rec.ct_dir, lost, rec.size};
  endfunction

endpackage

// File: rtl/lpc_rec_fifo.sv
// Synchronous record FIFO; a push while full is accepted when a pop
// happens in the same cycle. Also exposes the entry behind the head.
module lpc_rec_fifo
  import lpc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  lpc_rec_t      wdata,
  output lpc_rec_t      head,
  output lpc_rec_t      next_head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  lpc_rec_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push_ok, pop_ok;

  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (level == '0);
  assign push_ok   = push & (~full | pop);
  assign pop_ok    = pop & ~empty;
  assign head      = mem[rd_ptr];
  assign next_head = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lpc_rec_sched.sv
// Queues decoded LPC cycle records and serialises each as a byte frame
// (header, 4 address bytes, 0-4 data bytes) over valid/ready.
// Optional cycle-type filter: define LPC_REC_FILTER_EN.
module lpc_rec_sched
  import lpc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          lpc_clock,
  input  logic          lpc_reset,
  input  logic          in_valid,
  input  logic [3:0]    in_cyctype_dir,
  input  logic [31:0]   in_addr,
  input  logic [31:0]   in_data,
  input  logic [2:0]    in_data_size,
`ifdef LPC_REC_FILTER_EN
  input  logic [15:0]   cfg_ct_mask,
`endif
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic [AW:0]   fifo_level
);

  lpc_rec_t   in_rec, head, next_head, nxt;
  lpc_state_e state;
  logic [1:0] cnt;
  logic [2:0] nbytes, nm1;
  logic       accept, full, empty, hs, last, push_ok, drop, more, lost;

  assign in_rec = {in_cyctype_dir, in_addr, in_data, in_data_size};

`ifdef LPC_REC_FILTER_EN
  assign accept = in_valid & cfg_ct_mask[in_cyctype_dir];
`else
  assign accept = in_valid;
`endif

  always_comb begin
    hs      = tx_valid & tx_ready;
    nbytes  = data_bytes(head.size);
    nm1     = nbytes - 3'd1;
    last    = hs & (cnt == 2'd0) &
              ((state == ST_DATA) | ((state == ST_ADDR) & (nbytes == 3'd0)));
    push_ok = accept & (~full | last);
    drop    = accept & full & ~last;
    // After the pop the next head is either already queued or arriving now.
    more    = (fifo_level > (AW+1)'(1)) | push_ok;
    nxt     = (fifo_level > (AW+1)'(1)) ? next_head : in_rec;
  end

  lpc_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (lpc_clock),
    .rst       (lpc_reset),
    .push      (accept),
    .pop       (last),
    .wdata     (in_rec),
    .head      (head),
    .next_head (next_head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge lpc_clock) begin
    if (lpc_reset) begin
      state    <= ST_IDLE;
      cnt      <= 2'd0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      lost     <= 1'b0;
    end else begin
      if (drop)                        lost <= 1'b1;
      else if ((state == ST_HDR) & hs) lost <= 1'b0;

      if (last) begin
        if (more) begin
          state   <= ST_HDR;
          tx_data <= hdr_byte(nxt, lost);
        end else begin
          state    <= ST_IDLE;
          tx_valid <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: if (!empty) begin
            state    <= ST_HDR;
            tx_valid <= 1'b1;
            tx_data  <= hdr_byte(head, lost | drop);
          end
          ST_HDR: if (hs) begin
            state   <= ST_ADDR;
            cnt     <= 2'd3;
            tx_data <= head.addr[31:24];
          end else begin
            // A waiting header must report drops that occur while it stalls.
            tx_data[HDR_LOST_BIT] <= tx_data[HDR_LOST_BIT] | lost | drop;
          end
          ST_ADDR: if (hs) begin
            if (cnt != 2'd0) begin
              cnt     <= cnt - 2'd1;
              tx_data <= byte_sel(head.addr, cnt - 2'd1);
            end else begin
              state   <= ST_DATA;
              cnt     <= nm1[1:0];
              tx_data <= byte_sel(head.data, nm1[1:0]);
            end
          end
          ST_DATA: if (hs) begin
            cnt     <= cnt - 2'd1;
            tx_data <= byte_sel(head.data, cnt - 2'd1);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_rec_sched.sv
// Directed bench for lpc_rec_sched: expected frame bytes are queued when a
// record is strobed and checked as each byte is handshaken.
module tb_lpc_rec_sched;
  import lpc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_ct = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_size = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [2:0]  fifo_level;
`ifdef LPC_REC_FILTER_EN
  logic [15:0] cfg_ct_mask = 16'hFFFF;
`endif

  typedef struct { logic [7:0] b; int cyc; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;

  lpc_rec_sched #(.DEPTH(4)) dut (
    .lpc_clock      (clk),
    .lpc_reset      (rst),
    .in_valid       (in_valid),
    .in_cyctype_dir (in_ct),
    .in_addr        (in_addr),
    .in_data        (in_data),
    .in_data_size   (in_size),
`ifdef LPC_REC_FILTER_EN
    .cfg_ct_mask    (cfg_ct_mask),
`endif
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of one frame; hcyc < 0 means the cycle of each byte is not checked.
  task automatic expect_frame(input logic [3:0] ct, input logic [31:0] addr,
                              input logic [31:0] data, input logic [2:0] size,
                              input logic lost, input int hcyc);
    int n;
    logic [31:0] t;
    n = (size > 3'd4) ? 4 : int'(size);
    q.push_back('{{ct, lost, size}, hcyc});
    for (int i = 0; i < 4; i++) begin
      t = addr >> (8 * (3 - i));
      q.push_back('{t[7:0], (hcyc < 0) ? -1 : hcyc + 1 + i});
    end
    for (int j = 0; j < n; j++) begin
      t = data >> (8 * (n - 1 - j));
      q.push_back('{t[7:0], (hcyc < 0) ? -1 : hcyc + 5 + j});
    end
  endtask

  task automatic strobe(input logic [3:0] ct, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] size);
    in_ct = ct; in_addr = addr; in_data = data; in_size = size;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && tx_valid && tx_ready) begin
      tests++;
      assert (q.size() != 0) else begin
        fails++;
        $error("FAIL spurious_byte: got %0h expected none", tx_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("byte", {24'h0, tx_data}, {24'h0, e.b});
        if (e.cyc >= 0) chk("byte_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    repeat (3) tick();
    chk("reset_valid", {31'h0, tx_valid}, 32'h0);
    chk("reset_data", {24'h0, tx_data}, 32'h0);
    chk("reset_level", {29'h0, fifo_level}, 32'h0);
    rst = 1'b0;
    tick();

    // Single 16-bit memory write, header one cycle after capture.
    tx_ready = 1'b1;
    expect_frame(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2, 1'b0, cyc + 2);
    strobe(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2);
    repeat (10) tick();
    chk("single_drain", q.size(), 0);

    // Back-to-back frames with no gap.
    c = cyc;
    expect_frame(CT_MEM_WR, 32'h12347FE4, 32'h000069CD, 3'd4, 1'b0, c + 2);
    strobe(CT_MEM_WR, 32'h12347FE4, 32'h000069CD, 3'd4);
    expect_frame(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2, 1'b0, c + 11);
    strobe(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2);
    repeat (20) tick();
    chk("b2b_drain", q.size(), 0);

    // Backpressure while the second address byte is presented.
    expect_frame(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2, 1'b0, -1);
    strobe(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2);
    repeat (3) tick();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_data", {24'h0, tx_data}, 32'h34);
      chk("bp_valid", {31'h0, tx_valid}, 32'h1);
      tick();
    end
    chk("bp_data_end", {24'h0, tx_data}, 32'h34);
    tx_ready = 1'b1;
    repeat (10) tick();
    chk("bp_drain", q.size(), 0);

    // Overflow: five strobes into a depth-4 FIFO with the sink stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4)
        expect_frame(CT_MEM_WR, 32'h20000000 + i, 32'h1100 + i, 3'd2, (i == 0), -1);
      strobe(CT_MEM_WR, 32'h20000000 + i, 32'h1100 + i, 3'd2);
    end
    chk("ovf_level", {29'h0, fifo_level}, 32'd4);
    chk("ovf_hdr", {24'h0, tx_data}, 32'h6A);
    tx_ready = 1'b1;
    repeat (40) tick();
    chk("ovf_drain", q.size(), 0);
    chk("ovf_level_end", {29'h0, fifo_level}, 32'd0);

    // Reset after the second address byte has transferred.
    expect_frame(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2, 1'b0, -1);
    strobe(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2);
    repeat (4) tick();
    chk("rst_progress", q.size(), 4);
    rst = 1'b1;
    q.delete();
    tick();
    chk("rst_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_level", {29'h0, fifo_level}, 32'd0);
    rst = 1'b0;
    tick();
    expect_frame(CT_IO_WR, 32'h000000F0, 32'h000000A5, 3'd1, 1'b0, cyc + 2);
    strobe(CT_IO_WR, 32'h000000F0, 32'h000000A5, 3'd1);
    repeat (10) tick();
    chk("rst_clean_drain", q.size(), 0);

    // Size boundaries: 0 data bytes, size 7 clamped to 4, size 1.
    c = cyc;
    expect_frame(CT_MEM_RD, 32'hFEDCBA98, 32'h11223344, 3'd0, 1'b0, c + 2);
    strobe(CT_MEM_RD, 32'hFEDCBA98, 32'h11223344, 3'd0);
    expect_frame(CT_IO_RD, 32'h00000080, 32'hDEADBEEF, 3'd7, 1'b0, c + 7);
    strobe(CT_IO_RD, 32'h00000080, 32'hDEADBEEF, 3'd7);
    expect_frame(CT_IO_WR, 32'h0000002E, 32'h0000005A, 3'd1, 1'b0, c + 16);
    strobe(CT_IO_WR, 32'h0000002E, 32'h0000005A, 3'd1);
    repeat (25) tick();
    chk("size_drain", q.size(), 0);

`ifdef LPC_REC_FILTER_EN
    cfg_ct_mask = 16'h0040;
    strobe(CT_IO_WR, 32'h00000080, 32'h00000011, 3'd1);
    expect_frame(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2, 1'b0, -1);
    strobe(CT_MEM_WR, 32'h12347FE5, 32'h000069CE, 3'd2);
    repeat (15) tick();
    chk("filter_drain", q.size(), 0);
    chk("filter_level", {29'h0, fifo_level}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
